// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its sequencer: widths, op codes,
// hold latencies and the sequencer FSM state encoding.
package alu_pkg;

    localparam int DATA_W         = 32;
    localparam int OP_W           = 5;
    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 16;

    localparam logic [OP_W-1:0] OP_AND = 5'b00000;
    localparam logic [OP_W-1:0] OP_OR  = 5'b00001;
    localparam logic [OP_W-1:0] OP_XOR = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB = 5'b00100;
    localparam logic [OP_W-1:0] OP_MUL = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Two request channels plus one tagged response channel between the
// requesters (master side) and the ALU sequencer (slave side).
interface alu_sequencer_if #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W
);
    logic                req0_valid;
    logic                req0_ready;
    logic [DATA_W-1:0]   req0_a;
    logic [DATA_W-1:0]   req0_b;
    logic [OP_W-1:0]     req0_op;

    logic                req1_valid;
    logic                req1_ready;
    logic [DATA_W-1:0]   req1_a;
    logic [DATA_W-1:0]   req1_b;
    logic [OP_W-1:0]     req1_op;

    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_id;
    logic [2*DATA_W-1:0] rsp_data;
    logic                rsp_err;
    logic                busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

endinterface

// File: rtl/alu.sv
// Combinational ALU: 32-bit operands, 64-bit result. DIV returns
// {remainder, quotient}; unknown op codes produce zero.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W
) (
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    input  logic [OP_W-1:0]     i_op,
    output logic [2*DATA_W-1:0] o_c
);

    logic [2*DATA_W-1:0] w_a_ext;
    logic [2*DATA_W-1:0] w_b_ext;

    assign w_a_ext = {{DATA_W{1'b0}}, i_a};
    assign w_b_ext = {{DATA_W{1'b0}}, i_b};

    always_comb begin
        o_c = '0;
        case (i_op)
            OP_AND: o_c = {{DATA_W{1'b0}}, i_a & i_b};
            OP_OR:  o_c = {{DATA_W{1'b0}}, i_a | i_b};
            OP_XOR: o_c = {{DATA_W{1'b0}}, i_a ^ i_b};
            OP_ADD: o_c = {{DATA_W{1'b0}}, i_a + i_b};
            OP_SUB: o_c = {{DATA_W{1'b0}}, i_a - i_b};
            OP_MUL: o_c = w_a_ext * w_b_ext;
            OP_DIV: begin
                // The sequencer overrides this case with its own error result.
                if (i_b == '0) o_c = '1;
                else           o_c = {i_a % i_b, i_a / i_b};
            end
            default: o_c = '0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Round-robin two-port front end for the combinational ALU: registers the
// operands, holds them for an op-dependent time, returns the tagged result.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W     = alu_pkg::DATA_W,
    parameter int OP_W       = alu_pkg::OP_W,
    parameter int MUL_CYCLES = alu_pkg::MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = alu_pkg::DIV_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    alu_sequencer_if.slave  bus
);

    // state   | meaning
    // IDLE    | arbitrate; accept one request from port 0 or 1
    // BUSY    | operands held on the ALU, cnt counts down to capture
    // RESP    | response presented, waiting for rsp_ready

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;

    logic                r_last_grant;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [OP_W-1:0]     r_op;
    logic                r_id;
    logic [2*DATA_W-1:0] r_rsp_data;
    logic                r_rsp_err;

    logic                w_any;
    logic                w_win;
    logic                w_accept;
    logic                w_capture;
    logic [DATA_W-1:0]   w_sel_a;
    logic [DATA_W-1:0]   w_sel_b;
    logic [OP_W-1:0]     w_sel_op;
    logic [CNT_W-1:0]    w_lat_m1;
    logic                w_div_zero;
    logic [2*DATA_W-1:0] w_alu_c;

    // On a tie the port that did not win last time is served.
    assign w_any    = bus.req0_valid | bus.req1_valid;
    assign w_win    = (bus.req0_valid & bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
    assign w_sel_a  = w_win ? bus.req1_a  : bus.req0_a;
    assign w_sel_b  = w_win ? bus.req1_b  : bus.req0_b;
    assign w_sel_op = w_win ? bus.req1_op : bus.req0_op;

    always_comb begin
        w_lat_m1 = '0;
        if (w_sel_op == OP_MUL) begin
            w_lat_m1 = CNT_W'(MUL_CYCLES - 1);
        end else if ((w_sel_op == OP_DIV) && (w_sel_b != '0)) begin
            w_lat_m1 = CNT_W'(DIV_CYCLES - 1);
        end
    end

    assign w_div_zero = (r_op == OP_DIV) && (r_b == '0);

    alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .i_a  (r_a),
        .i_b  (r_b),
        .i_op (r_op),
        .o_c  (w_alu_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_accept        = 1'b0;
        w_capture       = 1'b0;
        bus.req0_ready  = 1'b0;
        bus.req1_ready  = 1'b0;
        bus.rsp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_accept       = 1'b1;
                    bus.req0_ready = ~w_win;
                    bus.req1_ready = w_win;
                    w_cnt_nxt      = w_lat_m1;
                    w_state_nxt    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_id         <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_accept) begin
                r_a          <= w_sel_a;
                r_b          <= w_sel_b;
                r_op         <= w_sel_op;
                r_id         <= w_win;
                r_last_grant <= w_win;
            end
            if (w_capture) begin
                r_rsp_data <= w_div_zero ? '1 : w_alu_c;
                r_rsp_err  <= w_div_zero;
            end
        end
    end

    assign bus.rsp_id   = r_id;
    assign bus.rsp_data = r_rsp_data;
    assign bus.rsp_err  = r_rsp_err;
    assign bus.busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a transaction-level model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int L_MUL = 4;
    localparam int L_DIV = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [64:0] model_result(input logic [4:0] op, input logic [31:0] a,
                                                 input logic [31:0] b);
        logic [31:0] s;
        logic [63:0] p;
        case (op)
            OP_AND: begin s = a & b; return {1'b0, 32'h0, s}; end
            OP_OR:  begin s = a | b; return {1'b0, 32'h0, s}; end
            OP_XOR: begin s = a ^ b; return {1'b0, 32'h0, s}; end
            OP_ADD: begin s = a + b; return {1'b0, 32'h0, s}; end
            OP_SUB: begin s = a - b; return {1'b0, 32'h0, s}; end
            OP_MUL: begin p = 64'(a) * 64'(b); return {1'b0, p}; end
            OP_DIV: begin
                if (b == 0) return {1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
            default: return 65'h0;
        endcase
    endfunction

    function automatic int model_latency(input logic [4:0] op, input logic [31:0] b);
        if (op == OP_MUL) return L_MUL;
        if (op == OP_DIV && b != 0) return L_DIV;
        return 1;
    endfunction

    // Transaction-level model: one op in flight, countdown to response.
    bit          m_inflight, m_in_resp, m_id, m_err;
    int          m_wait, m_last;
    logic [63:0] m_data;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_op;

    always @(negedge clk) begin
        logic [64:0] res;
        int          win;
        bit          v0, v1;
        if (!reset_n) begin
            m_inflight = 0; m_in_resp = 0; m_wait = 0; m_last = 1;
            check("rst_rsp_valid", bus.rsp_valid, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_rsp_data", bus.rsp_data, 0);
            check("rst_rsp_id", bus.rsp_id, 0);
            check("rst_rsp_err", bus.rsp_err, 0);
            check("rst_readies", {bus.req0_ready, bus.req1_ready}, 0);
        end else begin
            v0  = bus.req0_valid;
            v1  = bus.req1_valid;
            win = (v0 && v1) ? 1 - m_last : (v1 ? 1 : 0);
            check("ready0", bus.req0_ready, !m_inflight && v0 && win == 0);
            check("ready1", bus.req1_ready, !m_inflight && v1 && win == 1);
            check("rsp_valid", bus.rsp_valid, m_in_resp);
            check("busy", bus.busy, m_inflight);
            if (m_in_resp) begin
                check("rsp_data", bus.rsp_data, m_data);
                check("rsp_id", bus.rsp_id, m_id);
                check("rsp_err", bus.rsp_err, m_err);
            end else if (m_inflight) begin
                check("alu_a_hold", dut.u_alu.i_a, m_a);
                check("alu_b_hold", dut.u_alu.i_b, m_b);
                check("alu_op_hold", dut.u_alu.i_op, m_op);
            end
            if (m_in_resp) begin
                if (bus.rsp_ready) begin m_inflight = 0; m_in_resp = 0; end
            end else if (m_inflight) begin
                m_wait--;
                if (m_wait == 0) m_in_resp = 1;
            end else if (v0 || v1) begin
                m_inflight = 1;
                m_last     = win;
                m_id       = (win == 1);
                m_a        = win ? bus.req1_a  : bus.req0_a;
                m_b        = win ? bus.req1_b  : bus.req0_b;
                m_op       = win ? bus.req1_op : bus.req0_op;
                res        = model_result(m_op, m_a, m_b);
                m_err      = res[64];
                m_data     = res[63:0];
                m_wait     = model_latency(m_op, m_b);
            end
        end
    end

    int          grant_q[$];
    int          rid_q[$];
    logic [63:0] rdata_q[$];

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.req0_valid && bus.req0_ready) grant_q.push_back(0);
            if (bus.req1_valid && bus.req1_ready) grant_q.push_back(1);
            if (bus.rsp_valid && bus.rsp_ready) begin
                rid_q.push_back(int'(bus.rsp_id));
                rdata_q.push_back(bus.rsp_data);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send(input int port, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b);
        bit ok = 0;
        if (port == 0) begin
            bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((port == 0 && bus.req0_ready) || (port == 1 && bus.req1_ready)) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("accept_seen", ok, 1);
    endtask

    // Latency = edges after the accept edge until rsp_valid is observed.
    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                lat = k - 1;
                break;
            end
        end
        if (lat < 0) check("rsp_timeout", 0, 1);
    endtask

    task automatic directed(input string name, input int port, input logic [4:0] op,
                            input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                            input logic [63:0] exp_data, input bit exp_err);
        int lat;
        send(port, op, a, b);
        wait_rsp(lat);
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
        check({name, "_data"}, bus.rsp_data, exp_data);
        check({name, "_id"}, bus.rsp_id, 64'(port));
        check({name, "_err"}, bus.rsp_err, exp_err);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        reset_n        = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        bus.rsp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        directed("add_p0", 0, OP_ADD, 32'd5, 32'd3, 1, 64'd8, 1'b0);
        directed("mul_p1", 1, OP_MUL, 32'd6, 32'd3, 4, 64'd18, 1'b0);
        directed("mul_wide", 0, OP_MUL, 32'hFFFF_FFFF, 32'd2, 4, 64'h0000_0001_FFFF_FFFE, 1'b0);
        directed("unknown_op", 1, 5'b11111, 32'd3, 32'd4, 1, 64'd0, 1'b0);

        // Both ports contend continuously; port 1 won last, so port 0 goes first.
        grant_q.delete(); rid_q.delete(); rdata_q.delete();
        bus.req0_op = OP_SUB; bus.req0_a = 32'd8; bus.req0_b = 32'd4; bus.req0_valid = 1'b1;
        bus.req1_op = OP_DIV; bus.req1_a = 32'd8; bus.req1_b = 32'd4; bus.req1_valid = 1'b1;
        for (int i = 0; i < 200 && grant_q.size() < 4; i++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        for (int i = 0; i < 60 && rid_q.size() < 4; i++) @(posedge clk);
        #1;
        check("rr_grant_count", 64'(grant_q.size()), 4);
        check("rr_rsp_count", 64'(rid_q.size()), 4);
        if (grant_q.size() >= 4 && rid_q.size() >= 4) begin
            check("rr_grant0", 64'(grant_q[0]), 0);
            check("rr_grant1", 64'(grant_q[1]), 1);
            check("rr_grant2", 64'(grant_q[2]), 0);
            check("rr_grant3", 64'(grant_q[3]), 1);
            check("rr_rsp0", {rid_q[0] == 1, rdata_q[0][62:0]}, {1'b0, 63'd4});
            check("rr_rsp1", {rid_q[1] == 1, rdata_q[1][62:0]}, {1'b1, 63'd2});
            check("rr_rsp2", {rid_q[2] == 1, rdata_q[2][62:0]}, {1'b0, 63'd4});
            check("rr_rsp3", {rid_q[3] == 1, rdata_q[3][62:0]}, {1'b1, 63'd2});
        end

        directed("div_zero", 0, OP_DIV, 32'd9, 32'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

        // Backpressure: response must hold while a competing request waits.
        begin
            int lat;
            bus.rsp_ready = 1'b0;
            send(1, OP_ADD, 32'd7, 32'd9);
            wait_rsp(lat);
            check("bp_lat", 64'(lat), 1);
            @(posedge clk);
            #1;
            bus.req0_op = OP_ADD; bus.req0_a = 32'd1; bus.req0_b = 32'd2; bus.req0_valid = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check("bp_valid", bus.rsp_valid, 1);
                check("bp_data", bus.rsp_data, 64'd16);
                check("bp_id", bus.rsp_id, 1);
                check("bp_readies", {bus.req0_ready, bus.req1_ready}, 0);
                check("bp_busy", bus.busy, 1);
            end
            @(posedge clk);
            #1;
            bus.req0_valid = 1'b0;
            bus.rsp_ready  = 1'b1;
            @(posedge clk);
            #1;
            check("bp_idle_busy", bus.busy, 0);
            check("bp_idle_valid", bus.rsp_valid, 0);
        end

        // Asynchronous reset in the middle of a long divide.
        send(0, OP_DIV, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("arst_valid", bus.rsp_valid, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_data", bus.rsp_data, 0);
        check("arst_id_err", {bus.rsp_id, bus.rsp_err}, 0);
        @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("arst_no_rsp", 64'(seen), 0);
        @(posedge clk);
        #1;
        directed("post_rst_add", 0, OP_ADD, 32'd1, 32'd1, 1, 64'd2, 1'b0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
